// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the shift-add multiplier datapath and its BCD back end.
// Widths, FSM encodings and the BCD digit type live here so both blocks agree.
package bin2bcd_seq_pkg;

  localparam int BIN_W   = 8;  // product width of the multiplier
  localparam int NUM_DIG = 3;  // 10^3 > 2^8 - 1
  localparam int CNT_W   = 4;  // must be able to hold BIN_W
  localparam int DIG_W   = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef logic [DIG_W-1:0] digit_t;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift,
// so that doubling it carries correctly into the next decimal digit.
module bin2bcd_seq_add3
  import bin2bcd_seq_pkg::*;
(
  input  digit_t d,
  output digit_t q
);

  // d <= 9 during a conversion, so d + 3 <= 12 and always fits in 4 bits
  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Handshake: ld is sampled only while idle (busy=0); busy is high for the W
// cycles of a conversion and ld is ignored then; done pulses for one cycle
// when bcd is updated, and bcd holds that result until the next done.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W  = BIN_W,
  parameter int ND = NUM_DIG,
  parameter int CW = CNT_W
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [DIG_W*ND-1:0] bcd,
  output logic [0:0]          dbg_state
);

  localparam int BW  = DIG_W * ND;
  localparam int SRW = BW + W;
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [0:0]     state;
  logic [CW-1:0]  cnt;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] corrected;
  logic [SRW-1:0] sr_next;
  logic [BW-1:0]  adj;

  // Work register is {digits, remaining binary bits}; digits sit above bit W.
  for (genvar i = 0; i < ND; i++) begin : g_dig
    bin2bcd_seq_add3 u_add3 (
      .d (sr[W + DIG_W*i +: DIG_W]),
      .q (adj[DIG_W*i +: DIG_W])
    );
  end

  assign corrected = {adj, sr[W-1:0]};
  assign sr_next   = corrected << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr    <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (ld) begin
          sr    <= {{BW{1'b0}}, bin};
          cnt   <= CNT_INIT;
          state <= ST_SHIFT;
        end
      end else begin
        sr  <= sr_next;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_LAST) begin
          bcd   <= sr_next[SRW-1:W];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
      end
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign dbg_state = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: vector table, handshake corner cases, async reset
// abort and a full sweep of all 256 inputs against a decimal reference.
module tb_bin2bcd_seq;

  localparam int W = 8;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld  = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [0:0]  dbg_state;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic        prev_done = 1'b0;
  logic [11:0] mon_exp;
  logic [11:0] exp_q[$];
  vec_t        vecs[10];

  bin2bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("bcd_on_done", 32'(bcd), 32'(mon_exp));
      end
      if (prev_done) chk("done_single_pulse", 32'd1, 32'd0);
    end
    prev_done = done;
  end

  // driver: called just after a negedge; returns one negedge after t0
  task automatic start(input logic [7:0] v, input logic [11:0] e);
    bin = v;
    ld  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    ld = 1'b0;
  endtask

  // waits for done while scrambling bin; lat counts edges after t0
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      bin = 8'($urandom_range(0, 255));
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, bc, d0, n;
    logic hold_bad;

    vecs[0] = '{8'd99,  12'h099};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd0,   12'h000};
    vecs[3] = '{8'd100, 12'h100};
    vecs[4] = '{8'd9,   12'h009};
    vecs[5] = '{8'd128, 12'h128};
    vecs[6] = '{8'd1,   12'h001};
    vecs[7] = '{8'd250, 12'h250};
    vecs[8] = '{8'd59,  12'h059};
    vecs[9] = '{8'd199, 12'h199};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_bcd",   32'(bcd),  32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // table-driven conversions, including 99 (first case) and edge values
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].bin, vecs[i].exp);
      wait_done(lat, bc);
      chk("latency", 32'(lat), 32'(W));
      chk("busy_cycles", 32'(bc), 32'(W));
      chk("busy_low_on_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_cleared", 32'(done), 32'd0);
      chk("bcd_held", 32'(bcd), 32'(vecs[i].exp));
    end

    // ld while busy is ignored
    d0 = done_cnt;
    start(8'd42, 12'h042);
    repeat (2) @(negedge clk);
    bin = 8'd7;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    wait_done(lat, bc);
    chk("busy_ld_result", 32'(bcd), 32'h042);
    repeat (12) @(negedge clk);
    chk("busy_ld_one_done", 32'(done_cnt - d0), 32'd1);

    // ld accepted in the done cycle; old result holds until the new done
    start(8'd13, 12'h013);
    wait_done(lat, bc);
    bin = 8'd200;
    ld  = 1'b1;
    exp_q.push_back(12'h200);
    @(negedge clk);
    ld = 1'b0;
    n = 1;
    hold_bad = 1'b0;
    chk("done_cycle_ld_busy", 32'(busy), 32'd1);
    while (!done && n < 40) begin
      if (bcd !== 12'h013) hold_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("done_cycle_ld_hold", 32'(hold_bad), 32'd0);
    chk("done_cycle_ld_edges", 32'(n), 32'd9);
    chk("done_cycle_ld_result", 32'(bcd), 32'h200);
    @(negedge clk);

    // async reset mid-conversion aborts it
    bin = 8'd77;
    ld  = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_bcd",   32'(bcd),  32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_bcd_stays", 32'(bcd), 32'd0);

    // multiplier product 9 * 11 fed as bin
    start(8'(4'd9 * 8'd11), 12'h099);
    wait_done(lat, bc);
    @(negedge clk);

    // full sweep against the decimal reference
    for (int v = 0; v < 256; v++) begin
      start(8'(v), ref_bcd(v));
      wait_done(lat, bc);
      chk("sweep_latency", 32'(lat), 32'(W));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
